// File: rtl/multi_callback_timer_pkg.sv
// multi_callback_timer_pkg: shared channel state encoding and pulse-counter sizing
package multi_callback_timer_pkg;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] COUNT = 2'b01;
  localparam logic [1:0] FIRE  = 2'b10;
  function automatic int pulse_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/callback_channel.sv
// callback_channel: one countdown timer channel with one-shot/periodic mode and cancel
module callback_channel
  import multi_callback_timer_pkg::*;
#(
  parameter int ISIZE     = 16,
  parameter int PULSE_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [ISIZE-1:0] countdown,
  input  logic             periodic,
  input  logic             cancel,
  output logic             callback,
  output logic             busy
);
  localparam int PW = pulse_cnt_w(PULSE_LEN);
  logic [1:0]       state;
  logic [ISIZE-1:0] counter, reload;
  logic             mode;
  logic [PW-1:0]    pcnt_pulse;
  // channel FSM: cancel beats load beats normal counting/firing
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      reload     <= '0;
      mode       <= 1'b0;
      pcnt_pulse <= '0;
    end else if (cancel) state <= IDLE;
    else if (load) begin
      counter <= countdown;
      reload  <= countdown;
      mode    <= periodic;
      state   <= COUNT;
    end else case (state)
      COUNT:
        if (counter == '0) begin
          state      <= FIRE;
          pcnt_pulse <= PW'(PULSE_LEN - 1);
        end else if (tick) counter <= counter - ISIZE'(1);
      FIRE:
        if (pcnt_pulse == '0) begin
          state <= mode ? COUNT : IDLE;
          if (mode) counter <= reload;
        end else pcnt_pulse <= pcnt_pulse - PW'(1);
      default: state <= IDLE;
    endcase
  assign callback = state == FIRE;
  assign busy     = state != IDLE;
endmodule

// File: rtl/multi_callback_timer.sv
// multi_callback_timer: CHANNELS countdown callback timers sharing one prescaler (optional CALLBACK_IRQ_EN adds sticky irq_pending/irq_ack)
module multi_callback_timer
  import multi_callback_timer_pkg::*;
#(
  parameter int ISIZE     = 16,
  parameter int CHANNELS  = 4,
  parameter int PULSE_LEN = 2,
  parameter int PSIZE     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PSIZE-1:0]          prescale,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*ISIZE-1:0] countdown,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       cancel,
`ifdef CALLBACK_IRQ_EN
  input  logic [CHANNELS-1:0]       irq_ack,
  output logic [CHANNELS-1:0]       irq_pending,
`endif
  output logic [CHANNELS-1:0]       callback,
  output logic [CHANNELS-1:0]       busy,
  output logic                      any_callback
);
  logic [PSIZE-1:0] pcnt;
  logic             tick;
  assign tick = pcnt >= prescale;
  // free-running prescaler; >= keeps the period bounded when prescale drops mid-count
  always_ff @(posedge clk or negedge reset)
    if (!reset) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + PSIZE'(1);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    callback_channel #(.ISIZE(ISIZE), .PULSE_LEN(PULSE_LEN)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .load      (load[i]),
      .countdown (countdown[i*ISIZE +: ISIZE]),
      .periodic  (periodic[i]),
      .cancel    (cancel[i]),
      .callback  (callback[i]),
      .busy      (busy[i])
    );
  end
  assign any_callback = |callback;
`ifdef CALLBACK_IRQ_EN
  logic [CHANNELS-1:0] cb_q;
  // sticky pending flag set on each callback rise; a rise beats a simultaneous ack
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cb_q        <= '0;
      irq_pending <= '0;
    end else begin
      cb_q        <= callback;
      irq_pending <= (callback & ~cb_q) | (irq_pending & ~irq_ack);
    end
`endif
endmodule

// File: tb/tb_multi_callback_timer.sv
// tb_multi_callback_timer: randomized and directed checks of multi_callback_timer against a behavioural model
module tb_multi_callback_timer;
  localparam int IS = 16, CH = 4, PL = 2, PS = 8;
  logic clk = 1'b0, reset = 1'b0;
  logic [PS-1:0] prescale = '0;
  logic [CH-1:0] load = '0, periodic = '0, cancel = '0;
  logic [CH*IS-1:0] countdown = '0;
  logic [CH-1:0] callback, busy;
  logic any_callback;
`ifdef CALLBACK_IRQ_EN
  logic [CH-1:0] irq_ack = '0, irq_pending;
`endif
  int total = 0, bad = 0;
  multi_callback_timer #(.ISIZE(IS), .CHANNELS(CH), .PULSE_LEN(PL), .PSIZE(PS)) dut (
    .clk(clk), .reset(reset), .prescale(prescale), .load(load), .countdown(countdown),
    .periodic(periodic), .cancel(cancel),
`ifdef CALLBACK_IRQ_EN
    .irq_ack(irq_ack), .irq_pending(irq_pending),
`endif
    .callback(callback), .busy(busy), .any_callback(any_callback));
  always #5 clk = ~clk;
  // model: a channel is either armed (waiting for its count to drain) or firing for fire_left more cycles
  int m_armed[CH], m_cnt[CH], m_fire[CH], m_rel[CH], m_per[CH], m_p;
  int m_cbprev[CH], m_pend[CH];
  function automatic logic [CH-1:0] exp_cb();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_fire[i] > 0;
    return r;
  endfunction
  function automatic logic [CH-1:0] exp_busy();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_armed[i] != 0 || m_fire[i] > 0;
    return r;
  endfunction
  task automatic model_reset();
    m_p = 0;
    for (int i = 0; i < CH; i++) begin
      m_armed[i] = 0; m_cnt[i] = 0; m_fire[i] = 0; m_rel[i] = 0;
      m_per[i] = 0; m_cbprev[i] = 0; m_pend[i] = 0;
    end
  endtask
  task automatic model_edge();
    bit tk;
    if (!reset) begin
      model_reset();
      return;
    end
    tk = m_p >= int'(prescale);
    m_p = tk ? 0 : m_p + 1;
    for (int i = 0; i < CH; i++) begin
`ifdef CALLBACK_IRQ_EN
      m_pend[i] = ((m_fire[i] > 0) && !m_cbprev[i]) || (m_pend[i] && !irq_ack[i]) ? 1 : 0;
`endif
      m_cbprev[i] = m_fire[i] > 0 ? 1 : 0;
      if (cancel[i]) begin
        m_armed[i] = 0; m_fire[i] = 0;
      end else if (load[i]) begin
        m_armed[i] = 1; m_fire[i] = 0;
        m_cnt[i] = int'(countdown[i*IS +: IS]);
        m_rel[i] = m_cnt[i];
        m_per[i] = periodic[i] ? 1 : 0;
      end else if (m_fire[i] > 0) begin
        m_fire[i]--;
        if (m_fire[i] == 0 && m_per[i] != 0) begin
          m_armed[i] = 1; m_cnt[i] = m_rel[i];
        end
      end else if (m_armed[i] != 0) begin
        if (m_cnt[i] == 0) begin
          m_armed[i] = 0; m_fire[i] = PL;
        end else if (tk) m_cnt[i]--;
      end
    end
  endtask
  // one clock: advance the model with the inputs present at the edge, then compare all outputs
  task automatic step(input string tag);
    logic [CH-1:0] ec, eb;
    @(posedge clk);
    model_edge();
    #1;
    ec = exp_cb();
    eb = exp_busy();
    total++;
    if (callback !== ec) begin bad++; $display("FAIL %s callback got=%b exp=%b", tag, callback, ec); end
    total++;
    if (busy !== eb) begin bad++; $display("FAIL %s busy got=%b exp=%b", tag, busy, eb); end
    total++;
    if (any_callback !== |ec) begin bad++; $display("FAIL %s any_callback got=%b exp=%b", tag, any_callback, |ec); end
`ifdef CALLBACK_IRQ_EN
    begin
      logic [CH-1:0] ep;
      for (int i = 0; i < CH; i++) ep[i] = m_pend[i] != 0;
      total++;
      if (irq_pending !== ep) begin bad++; $display("FAIL %s irq_pending got=%b exp=%b", tag, irq_pending, ep); end
    end
`endif
  endtask
  task automatic do_reset();
    reset = 1'b0;
    load = '0; cancel = '0; periodic = '0;
`ifdef CALLBACK_IRQ_EN
    irq_ack = '0;
`endif
    step("rst_hold");
    step("rst_hold");
    reset = 1'b1;
  endtask
  task automatic test_reset();
    model_reset();
    do_reset();
    for (int k = 0; k < 50; k++) step("idle");
  endtask
  task automatic test_oneshot();
    do_reset();
    prescale = 0;
    countdown[0 +: IS] = 16'd5;
    load = 4'b0001;
    step("os_load");
    load = '0;
    for (int k = 1; k <= 9; k++) begin
      step("os");
      total++;
      if (callback[0] !== logic'(k == 6 || k == 7)) begin
        bad++; $display("FAIL os_cb k=%0d got=%b exp=%b", k, callback[0], k == 6 || k == 7);
      end
      total++;
      if (busy[0] !== logic'(k < 8)) begin
        bad++; $display("FAIL os_busy k=%0d got=%b exp=%b", k, busy[0], k < 8);
      end
    end
  endtask
  task automatic test_periodic();
    int rises[$];
    logic prev;
    do_reset();
    prescale = 3;
    countdown[IS +: IS] = 16'd2;
    periodic = 4'b0010;
    load = 4'b0010;
    step("per_load");
    load = '0;
    prev = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step("per");
      if (callback[1] && !prev) rises.push_back(k);
      prev = callback[1];
    end
    total++;
    if (rises.size() < 4) begin bad++; $display("FAIL per_count got=%0d exp>=4", rises.size()); end
    for (int j = 1; j < rises.size(); j++) begin
      total++;
      if (rises[j] - rises[j-1] < 8 || rises[j] - rises[j-1] > 11) begin
        bad++; $display("FAIL per_gap got=%0d exp=8..11", rises[j] - rises[j-1]);
      end
    end
    for (int k = 0; k < 20 && !callback[1]; k++) step("per_wait");
    total++;
    if (!callback[1]) begin bad++; $display("FAIL per_timeout got=%b exp=1", callback[1]); end
    cancel = 4'b0010;
    step("per_cancel");
    cancel = '0;
    total++;
    if (callback[1] !== 1'b0 || busy[1] !== 1'b0) begin
      bad++; $display("FAIL per_cancel cb=%b busy=%b exp=0 0", callback[1], busy[1]);
    end
  endtask
  task automatic test_zero_conflict();
    do_reset();
    prescale = 0;
    countdown[2*IS +: IS] = 16'd0;
    countdown[3*IS +: IS] = 16'd9;
    load = 4'b1100;
    cancel = 4'b1000;
    step("zc_load");
    load = '0; cancel = '0;
    total++;
    if (callback[2] !== 1'b0 || busy[2] !== 1'b1 || busy[3] !== 1'b0) begin
      bad++; $display("FAIL zc_first cb2=%b busy2=%b busy3=%b exp=0 1 0", callback[2], busy[2], busy[3]);
    end
    step("zc");
    total++;
    if (callback[2] !== 1'b1) begin bad++; $display("FAIL zc_fire got=%b exp=1", callback[2]); end
    for (int k = 0; k < 3; k++) step("zc_tail");
  endtask
  task automatic test_all_and_reset();
    do_reset();
    prescale = 0;
    countdown = {16'd0, 16'd7, 16'd3, 16'd3};
    load = 4'b1111;
    step("all_load");
    load = '0;
    for (int k = 0; k < 12; k++) step("all");
    countdown = {16'd50, 16'd50, 16'd50, 16'd50};
    periodic = 4'b0101;
    load = 4'b1111;
    step("mid_load");
    load = '0;
    for (int k = 0; k < 5; k++) step("mid");
    reset = 1'b0;
    #1;
    total++;
    if (callback !== '0 || busy !== '0 || any_callback !== 1'b0) begin
      bad++; $display("FAIL async_rst cb=%b busy=%b any=%b exp=0", callback, busy, any_callback);
    end
    model_reset();
    do_reset();
    for (int k = 0; k < 5; k++) step("post_rst");
  endtask
`ifdef CALLBACK_IRQ_EN
  task automatic test_irq();
    logic prev;
    do_reset();
    prescale = 0;
    countdown[0 +: IS] = 16'd0;
    periodic = 4'b0001;
    load = 4'b0001;
    step("irq_load");
    load = '0;
    prev = callback[0];
    for (int k = 0; k < 20 && !(callback[0] && !prev); k++) begin
      prev = callback[0];
      step("irq_wait");
    end
    irq_ack = 4'b0001;
    step("irq_ack_rise");
    total++;
    if (irq_pending[0] !== 1'b1) begin bad++; $display("FAIL irq_set_wins got=%b exp=1", irq_pending[0]); end
    step("irq_ack");
    irq_ack = '0;
    total++;
    if (irq_pending[0] !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq_pending[0]); end
    cancel = 4'b0001;
    step("irq_cancel");
    cancel = '0;
  endtask
`endif
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 49) == 0) prescale = PS'($urandom_range(0, 5));
      for (int i = 0; i < CH; i++) begin
        load[i] = $urandom_range(0, 15) == 0;
        cancel[i] = $urandom_range(0, 39) == 0;
        periodic[i] = $urandom_range(0, 1) == 1;
        countdown[i*IS +: IS] = IS'($urandom_range(0, 12));
`ifdef CALLBACK_IRQ_EN
        irq_ack[i] = $urandom_range(0, 5) == 0;
`endif
      end
      step("rnd");
    end
    load = '0; cancel = '0;
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_zero_conflict();
    test_all_and_reset();
`ifdef CALLBACK_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_callback_timer.md
Name: multi_callback_timer

Overview:
Parametrised multi-channel successor to the single-shot countdown callback. It provides CHANNELS independent countdown timers sharing one prescaler. Each channel supports one-shot or periodic mode, a configurable callback pulse width, and cancel. It sits beside the CPU core as the timer/event source for scheduled callbacks and interrupts.

Parameters:
ISIZE, 16, countdown counter width per channel
CHANNELS, 4, number of independent timer channels
PULSE_LEN, 2, callback pulse width in clk cycles (>=1); default covers the short-pulse margin issue
PSIZE, 8, prescaler width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state immediately
prescale  in  PSIZE  global tick divider; one tick every prescale+1 clk cycles
load  in  CHANNELS  per-channel start strobe (1 cycle)
countdown  in  CHANNELS*ISIZE  per-channel start/reload value, channel i at [i*ISIZE +: ISIZE]
periodic  in  CHANNELS  sampled with load; 1 = auto-reload after each callback
cancel  in  CHANNELS  per-channel abort strobe
callback  out  CHANNELS  registered callback pulse, PULSE_LEN cycles wide
busy  out  CHANNELS  channel not IDLE
any_callback  out  1  OR of callback

Behaviour:
- Reset asserted (reset=0): prescaler count 0; all channels IDLE; counter, reload and mode regs 0; callback=0, busy=0, any_callback=0. Unlike the old block, nothing fires after reset.
- Prescaler: free-running pcnt. tick=1 when pcnt>=prescale, then pcnt<=0; otherwise pcnt+1. prescale=0 gives tick every cycle. The >= compare bounds the period when prescale is lowered mid-count.
- Per-channel FSM, states IDLE, COUNT, FIRE. Priority per cycle: cancel > load > normal.
- cancel: go to IDLE next edge from any state; callback drops next cycle; reload value kept.
- load in any state: counter<=countdown, reload<=countdown, mode<=periodic, state<=COUNT. Load during FIRE truncates the pulse.
- COUNT: if counter==0, go to FIRE with pcnt_pulse<=PULSE_LEN-1 (no tick needed). Else if tick, counter-1.
- FIRE: callback=1. pcnt_pulse decrements every clk (not prescaled). At 0: if mode periodic, counter<=reload and go to COUNT; else go to IDLE.
- Latency at prescale=0: load sampled at edge E0, callback high from edge E0+countdown+1 for PULSE_LEN cycles. countdown=0 gives callback at E0+1.
- Periodic period at prescale=0: countdown+1+PULSE_LEN cycles between rising callback edges.
- Counter never wraps: decrement occurs only when counter!=0.
- callback, busy and any_callback are registered/state-derived; no combinational path from inputs.
- Reset mid-operation: everything returns to reset values asynchronously; no pulse completes.

Optional Feature:
CALLBACK_IRQ_EN. Defined: adds ports irq_ack in CHANNELS and irq_pending out CHANNELS. irq_pending[i] sets on the rising edge of callback[i] and is sticky until irq_ack[i]. Set wins over simultaneous ack. Reset clears it. Undefined: ports absent; behaviour otherwise identical.

Decomposition:
- Package multi_callback_timer_pkg: channel state encoding (IDLE=2'b00, COUNT=2'b01, FIRE=2'b10), pulse-counter width function clog2(PULSE_LEN+1).
- Sub-module callback_channel: one FSM, counter, reload and pulse counter; takes tick. Instantiated CHANNELS times in a generate loop.
- Prescaler and the any_callback OR stay in the top level.

Test Plan:
- Reset release, no load, 50 cycles -> callback=0, busy=0 throughout.
- prescale=0, ch0 load countdown=5 one-shot -> callback[0] high on cycles 6-7 after load edge, then busy[0]=0.
- prescale=3, ch1 periodic countdown=2 -> first callback 4*2+1=9 cycles after load (±tick phase 3); repeats every ~11 cycles until cancel; cancel mid-FIRE drops callback next cycle.
- ch2 load countdown=0 -> callback on the next cycle; simultaneous load+cancel on ch3 -> ch3 stays IDLE.
- All 4 channels loaded with 3,3,7,0 same cycle -> independent pulses; any_callback is the OR; reset=0 mid-count clears all immediately.
- CALLBACK_IRQ_EN defined: callback sets irq_pending; ack clears it; ack coincident with a new callback rise leaves it set.
